sw_input_port: RTL

- Processor-side reader for the 8-bit SW switch bus; the bench and the board are the writers that drive SW.
- Performs 2-flop synchronisation and whole-bus debouncing of SW.
- Each debounced change is queued as an event in a small FIFO.
- The core pops events with a read strobe; the current debounced value is also always visible.

---
 rtl/sw_port_pkg.sv | 15 +
 rtl/sw_input_port_fifo.sv | 74 +++++++
 rtl/sw_input_port.sv | 101 ++++++++++
 3 files changed

// File: rtl/sw_port_pkg.sv
// Shared types and defaults for the SW switch-bus input port.
package sw_port_pkg;

    localparam int SW_W                = 8;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_FIFO_DEPTH      = 4;

    typedef logic [SW_W-1:0] sw_event_t;

    // Counter width helper: never narrower than one bit.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_input_port_fifo.sv
// Synchronous event FIFO with registered pop data and a one-cycle read-valid pulse.
module sync_fifo #(
    parameter  int WIDTH   = 8,
    parameter  int DEPTH   = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_push_data,
    input  logic               i_pop,
    output logic [WIDTH-1:0]   o_rd_data,
    output logic               o_rd_valid,
    output logic               o_full,
    output logic               o_empty,
    output logic [COUNT_W-1:0] o_count
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [COUNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_rd_data;
    logic               r_rd_valid;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full    = (r_count == COUNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !w_empty;
    // A push into a full FIFO still lands when the same edge frees a slot.
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop_ok;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;

endmodule

// File: rtl/sw_input_port.sv
// SW bus reader: 2-flop sync, whole-bus debounce, change events queued for the core.
module sw_input_port
    import sw_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int CNT_W           = min1_clog2(DEBOUNCE_CYCLES)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  sw_event_t                         sw_in,
    input  logic                              rd_en,
    input  logic                              ovf_clr,
    output sw_event_t                         sw_stable,
    output sw_event_t                         rd_data,
    output logic                              rd_valid,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    sw_event_t        r_s1;
    sw_event_t        r_s2;
    sw_event_t        r_cand;
    sw_event_t        r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_overflow;

    logic w_accept;
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_pop_ok;
    logic w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw_in;
            r_s2 <= r_s1;
        end
    end

    // Accept when the candidate has held for the full window and differs from sw_stable.
    assign w_accept = (r_s2 == r_cand) && (r_cnt == CNT_MAX) && (r_cand != r_stable);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand   <= '0;
            r_cnt    <= '0;
            r_stable <= '0;
        end else begin
            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_accept) begin
                r_stable <= r_cand;
            end
        end
    end

    assign w_pop_ok = rd_en && !w_fifo_empty;
    assign w_drop   = w_accept && w_fifo_full && !w_pop_ok;

    // A drop on the same edge as ovf_clr leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (SW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_push      (w_accept),
        .i_push_data (r_cand),
        .i_pop       (rd_en),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (count)
    );

    assign sw_stable = r_stable;
    assign empty     = w_fifo_empty;
    assign overflow  = r_overflow;

endmodule
